mem_burst_master: RTL and testbench
===================================

Name: mem_burst_master

Overview:
- Initiator side of the SimpleCPU memory port.
- Accepts single-access and burst-read requests from the CPU/cache side and drives the memory enable/addr/rw/access_size/din interface.
- Counts and collects returned beats, then streams them back with a beat index and a last flag.
- Rejects illegal requests locally with an error response, without touching memory.

Parameters:
- START_ADDR, 32'h8002_0000, base physical address of the memory window.
- SIZE, 1024, memory window size in bytes; legal addresses are START_ADDR .. START_ADDR+SIZE-1.
- TIMEOUT, 64, maximum cycles to wait for mem_busy low before issuing (used only with the optional feature).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request (high only in IDLE).
- req_rw  in  1  1 = write, 0 = read.
- req_size  in  3  access-size code (package enum).
- req_addr  in  32  physical byte address.
- req_wdata  in  32  write data, right-aligned.
- resp_valid  out  1  one-cycle pulse per returned beat or completion.
- resp_data  out  32  read beat data; 0 for writes and errors.
- resp_index  out  4  beat number, 0-based.
- resp_last  out  1  final beat of the transaction.
- resp_err  out  1  transaction rejected; valid with resp_valid.
- mem_enable  out  1  one-cycle request strobe to memory.
- mem_addr  out  32  address driven with mem_enable.
- mem_access_size  out  3  size code driven with mem_enable.
- mem_rw  out  1  direction driven with mem_enable.
- mem_din  out  32  write data driven with mem_enable.
- mem_dout  in  32  memory read data, one beat per cycle.
- mem_busy  in  1  memory still streaming a burst.

Behaviour:
- Reset (async): state IDLE, beat counter 0, every output 0 except req_ready=1.
- Reset asserted mid-burst abandons the transaction silently, with no response.
- Size codes:
  - 000 word: 1 beat
  - 001 4-word burst
  - 010 8-word burst
  - 011 16-word burst
  - 100 byte: 1 beat
  - 101 half-word: 1 beat
  - 110 and 111 illegal
- Beat count N = 1/4/8/16.
- Legality check, evaluated at acceptance. A request is illegal if any of:
  - the size code is illegal;
  - the address lies outside the window, or the last byte addr+4N-1 (or addr+width-1 for single accesses) exceeds the window;
  - it is misaligned: word/burst addresses must be 4-aligned, half-word 2-aligned;
  - it is a write with a burst size.
- FSM states:
  - IDLE: req_ready=1. On req_valid, the request is latched. Legal requests go to WAIT; illegal requests go to ERR.
  - WAIT: stay while mem_busy=1. When mem_busy=0, go to ISSUE.
  - ISSUE (1 cycle): mem_enable=1 with the latched addr/size/rw/din. Reads go to DATA; writes go to WDONE.
  - DATA: mem_dout sampled on each of the N edges following ISSUE, beat counter 0..N-1. Each sample produces a registered resp_valid in the next cycle, with resp_index equal to the counter. resp_last is set on beat N-1, after which the FSM returns to IDLE.
  - WDONE (1 cycle): resp_valid=1, resp_last=1, resp_data=0. Then IDLE.
  - ERR (1 cycle): resp_valid=1, resp_err=1, resp_last=1, resp_data=0, resp_index=0. Then IDLE. No mem_enable is ever issued for an error.
- Read latency, with acceptance edge E0 and mem_busy=0:
  - ISSUE occupies cycle E0..E1;
  - beat k is sampled at edge E2+k;
  - resp_valid for beat k is high during cycle E2+k..E3+k.
- Byte/half-word reads: resp_data is mem_dout masked to bits [7:0] / [15:0] and zero-extended.
- Writes: mem_din = req_wdata unchanged. The memory uses the low bits for byte/half-word accesses.
- The response sink has no backpressure and must accept every pulse.
- mem_enable is never asserted while mem_busy=1.
- The mem_* outputs other than mem_enable hold their last value when idle.

Optional Feature:
- Macro: MEM_MASTER_TIMEOUT_EN.
- Defined: a counter runs in WAIT. If mem_busy stays high for TIMEOUT consecutive cycles, the FSM goes to ERR, giving a resp_err pulse with no issue; the counter is cleared on leaving WAIT.
- Undefined: WAIT waits indefinitely and the counter logic is absent.

Decomposition:
- Package mem_pkg holds:
  - the access-size enum (SZ_WORD, SZ_BURST4, SZ_BURST8, SZ_BURST16, SZ_BYTE, SZ_HALF);
  - the FSM state enum;
  - a beats_for_size constant function;
  - the default START_ADDR.
- One sub-module, mem_req_check: a combinational legality checker for size, window, alignment and write-burst. It is natural to share it with a future store buffer.

Test Plan:
- 8-word burst read at 32'h8002_0020, memory words 0x1000+i, mem_busy=0 → 8 resp_valid pulses on consecutive cycles, data 0x1000..0x1007, index 0..7, last only on index 7; first pulse 2 cycles after acceptance.
- Byte write 0xA5 to 32'h8002_0003, then byte read of the same address → one mem_enable with rw=1, din=0x000000A5; WDONE pulse; the read returns resp_data=0x000000A5.
- Misaligned word read 32'h8002_0002, 4-word burst write, and address 32'h8002_0400 (SIZE=1024) → each gives resp_err=1, resp_last=1 one cycle after acceptance; mem_enable is never asserted.
- mem_busy held high 5 cycles when a request arrives → mem_enable asserts only in the cycle after mem_busy drops; data as expected. With MEM_MASTER_TIMEOUT_EN and TIMEOUT=4, mem_busy held high 10 cycles → resp_err after 4 WAIT cycles.
- rst pulsed during beat 3 of a 16-beat read → outputs go to reset values immediately; no further resp_valid; the next request completes normally.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types for the SimpleCPU memory-port initiator: access-size codes, FSM
// states, default window base and the beat-count helper.
package mem_pkg;

  typedef enum logic [2:0] {
    SZ_WORD    = 3'b000,
    SZ_BURST4  = 3'b001,
    SZ_BURST8  = 3'b010,
    SZ_BURST16 = 3'b011,
    SZ_BYTE    = 3'b100,
    SZ_HALF    = 3'b101
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ISSUE,
    ST_DATA,
    ST_WDONE,
    ST_ERR
  } state_e;

  localparam logic [31:0] DEF_START_ADDR = 32'h8002_0000;

  function automatic logic [4:0] beats_for_size(input logic [2:0] sz);
    case (sz)
      SZ_BURST4:  return 5'd4;
      SZ_BURST8:  return 5'd8;
      SZ_BURST16: return 5'd16;
      default:    return 5'd1;
    endcase
  endfunction

endpackage

// File: rtl/mem_req_check.sv
// Combinational legality check for a memory request: size code, window bounds,
// alignment and write-with-burst. Shareable with other initiators.
module mem_req_check
  import mem_pkg::*;
#(
  parameter logic [31:0] START_ADDR = DEF_START_ADDR,
  parameter int unsigned SIZE       = 1024
) (
  input  logic [2:0]  i_size,
  input  logic [31:0] i_addr,
  input  logic        i_rw,
  output logic        o_illegal
);

  logic [32:0] w_len;
  logic [32:0] w_last;
  logic [32:0] w_win_end;
  logic        w_bad_size;
  logic        w_bad_align;
  logic        w_wr_burst;
  logic        w_outside;

  always_comb begin
    w_bad_size  = 1'b0;
    w_bad_align = 1'b0;
    w_wr_burst  = 1'b0;
    w_len       = 33'd4;
    case (i_size)
      SZ_WORD: w_bad_align = |i_addr[1:0];
      SZ_BURST4, SZ_BURST8, SZ_BURST16: begin
        w_len       = {26'd0, beats_for_size(i_size), 2'b00};
        w_bad_align = |i_addr[1:0];
        w_wr_burst  = i_rw;
      end
      SZ_BYTE: w_len = 33'd1;
      SZ_HALF: begin
        w_len       = 33'd2;
        w_bad_align = i_addr[0];
      end
      default: w_bad_size = 1'b1;
    endcase
    // 33-bit math so a request near 2^32 cannot wrap back into the window
    w_last    = {1'b0, i_addr} + w_len - 33'd1;
    w_win_end = {1'b0, START_ADDR} + 33'(SIZE) - 33'd1;
    w_outside = (i_addr < START_ADDR) || (w_last > w_win_end);
    o_illegal = w_bad_size | w_bad_align | w_wr_burst | w_outside;
  end

endmodule

// File: rtl/mem_burst_master.sv
// SimpleCPU memory-port initiator: single and burst accesses, local rejection of
// illegal requests. Optional WAIT timeout enabled by MEM_MASTER_TIMEOUT_EN.
//
// state    | meaning
// IDLE     | req_ready high, latch request on req_valid
// WAIT     | legal request held while mem_busy is high
// ISSUE    | one-cycle mem_enable strobe
// DATA     | collect N read beats, one response pulse per beat
// WDONE    | write completion pulse
// ERR      | error pulse, memory untouched
module mem_burst_master
  import mem_pkg::*;
#(
  parameter logic [31:0] START_ADDR = DEF_START_ADDR,
  parameter int unsigned SIZE       = 1024,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rw,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic [3:0]  resp_index,
  output logic        resp_last,
  output logic        resp_err,
  output logic        mem_enable,
  output logic [31:0] mem_addr,
  output logic [2:0]  mem_access_size,
  output logic        mem_rw,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout,
  input  logic        mem_busy
);

  state_e      r_state;
  logic [3:0]  r_beat;
  logic        r_rw;
  logic [2:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_req_ready;
  logic        r_resp_valid;
  logic [31:0] r_resp_data;
  logic [3:0]  r_resp_index;
  logic        r_resp_last;
  logic        r_resp_err;
  logic        r_mem_enable;
  logic [31:0] r_mem_addr;
  logic [2:0]  r_mem_size;
  logic        r_mem_rw;
  logic [31:0] r_mem_din;

  logic        w_illegal;
  logic [4:0]  w_n;
  logic        w_beat_last;
  logic [31:0] w_rdata;

`ifdef MEM_MASTER_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0] r_tmo;
`endif

  mem_req_check #(
    .START_ADDR(START_ADDR),
    .SIZE      (SIZE)
  ) u_check (
    .i_size   (req_size),
    .i_addr   (req_addr),
    .i_rw     (req_rw),
    .o_illegal(w_illegal)
  );

  assign w_n         = beats_for_size(r_size);
  assign w_beat_last = ({1'b0, r_beat} == (w_n - 5'd1));

  always_comb begin
    case (r_size)
      SZ_BYTE: w_rdata = {24'd0, mem_dout[7:0]};
      SZ_HALF: w_rdata = {16'd0, mem_dout[15:0]};
      default: w_rdata = mem_dout;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_beat       <= '0;
      r_rw         <= 1'b0;
      r_size       <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_resp_index <= '0;
      r_resp_last  <= 1'b0;
      r_resp_err   <= 1'b0;
      r_mem_enable <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_size   <= '0;
      r_mem_rw     <= 1'b0;
      r_mem_din    <= '0;
`ifdef MEM_MASTER_TIMEOUT_EN
      r_tmo        <= '0;
`endif
    end else begin
      // response and strobe outputs are single-cycle pulses
      r_mem_enable <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_last  <= 1'b0;
      r_resp_data  <= '0;
      r_resp_index <= '0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_rw        <= req_rw;
            r_size      <= req_size;
            r_addr      <= req_addr;
            r_wdata     <= req_wdata;
            r_req_ready <= 1'b0;
            if (w_illegal) begin
              r_state      <= ST_ERR;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_last  <= 1'b1;
            end else if (mem_busy) begin
              r_state <= ST_WAIT;
`ifdef MEM_MASTER_TIMEOUT_EN
              r_tmo   <= TW'(TIMEOUT - 1);
`endif
            end else begin
              r_state      <= ST_ISSUE;
              r_mem_enable <= 1'b1;
              r_mem_addr   <= req_addr;
              r_mem_size   <= req_size;
              r_mem_rw     <= req_rw;
              r_mem_din    <= req_wdata;
            end
          end
        end
        ST_WAIT: begin
          if (!mem_busy) begin
            r_state      <= ST_ISSUE;
            r_mem_enable <= 1'b1;
            r_mem_addr   <= r_addr;
            r_mem_size   <= r_size;
            r_mem_rw     <= r_rw;
            r_mem_din    <= r_wdata;
`ifdef MEM_MASTER_TIMEOUT_EN
            r_tmo        <= '0;
`endif
          end
`ifdef MEM_MASTER_TIMEOUT_EN
          else if (r_tmo == '0) begin
            r_state      <= ST_ERR;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b1;
            r_resp_last  <= 1'b1;
          end else begin
            r_tmo <= r_tmo - TW'(1);
          end
`endif
        end
        ST_ISSUE: begin
          if (r_rw) begin
            r_state      <= ST_WDONE;
            r_resp_valid <= 1'b1;
            r_resp_last  <= 1'b1;
          end else begin
            r_state <= ST_DATA;
            r_beat  <= '0;
          end
        end
        ST_DATA: begin
          r_resp_valid <= 1'b1;
          r_resp_data  <= w_rdata;
          r_resp_index <= r_beat;
          if (w_beat_last) begin
            r_resp_last <= 1'b1;
            r_beat      <= '0;
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b1;
          end else begin
            r_beat <= r_beat + 4'd1;
          end
        end
        ST_WDONE, ST_ERR: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b1;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready       = r_req_ready;
  assign resp_valid      = r_resp_valid;
  assign resp_data       = r_resp_data;
  assign resp_index      = r_resp_index;
  assign resp_last       = r_resp_last;
  assign resp_err        = r_resp_err;
  assign mem_enable      = r_mem_enable;
  assign mem_addr        = r_mem_addr;
  assign mem_access_size = r_mem_size;
  assign mem_rw          = r_mem_rw;
  assign mem_din         = r_mem_din;

endmodule

// File: tb/tb_mem_burst_master.sv
// Directed bench for mem_burst_master: vector table plus reset-mid-burst and
// (with MEM_MASTER_TIMEOUT_EN) WAIT timeout sequences.
module tb_mem_burst_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_rw;
  logic [2:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [3:0]  resp_index;
  logic        resp_last;
  logic        resp_err;
  logic        mem_enable;
  logic [31:0] mem_addr;
  logic [2:0]  mem_access_size;
  logic        mem_rw;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
  logic        mem_busy;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mem_burst_master #(
    .START_ADDR(32'h8002_0000),
    .SIZE      (1024),
    .TIMEOUT   (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_rw         (req_rw),
    .req_size       (req_size),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_data      (resp_data),
    .resp_index     (resp_index),
    .resp_last      (resp_last),
    .resp_err       (resp_err),
    .mem_enable     (mem_enable),
    .mem_addr       (mem_addr),
    .mem_access_size(mem_access_size),
    .mem_rw         (mem_rw),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_busy       (mem_busy)
  );

  // ---------------- memory model: byte array, sync read, 1 beat/cycle ------
  logic [7:0] mbytes [0:1023];
  logic       init_mem;
  int         m_rem;
  logic [9:0] m_next;
  logic [9:0] w_off;
  assign w_off = mem_addr[9:0];

  function automatic logic [7:0] init_byte(input int i);
    return 8'((32'h0FF8 + 32'(i / 4)) >> (8 * (i % 4)));
  endfunction

  function automatic logic [31:0] rd_word(input logic [9:0] o);
    return {mbytes[o + 10'd3], mbytes[o + 10'd2], mbytes[o + 10'd1], mbytes[o]};
  endfunction

  function automatic int model_beats(input logic [2:0] sz);
    case (sz)
      3'b001:  return 4;
      3'b010:  return 8;
      3'b011:  return 16;
      default: return 1;
    endcase
  endfunction

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 1024; i++) mbytes[i] <= init_byte(i);
      m_rem    <= 0;
      m_next   <= '0;
      mem_dout <= '0;
    end else if (mem_enable) begin
      if (mem_rw) begin
        mbytes[w_off] <= mem_din[7:0];
        if (mem_access_size != 3'b100) mbytes[w_off + 10'd1] <= mem_din[15:8];
        if (mem_access_size == 3'b000) begin
          mbytes[w_off + 10'd2] <= mem_din[23:16];
          mbytes[w_off + 10'd3] <= mem_din[31:24];
        end
        m_rem <= 0;
      end else begin
        case (mem_access_size)
          3'b100:  mem_dout <= {24'hDEADBE, mbytes[w_off]};
          3'b101:  mem_dout <= {16'hBEEF, mbytes[w_off + 10'd1], mbytes[w_off]};
          default: mem_dout <= rd_word(w_off);
        endcase
        m_rem  <= model_beats(mem_access_size) - 1;
        m_next <= w_off + 10'd4;
      end
    end else if (m_rem > 0) begin
      mem_dout <= rd_word(m_next);
      m_next   <= m_next + 10'd4;
      m_rem    <= m_rem - 1;
    end
  end

  // ---------------- checking helpers ----------------------------------------
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
  endtask

  // rcyc/ecyc: cycle (1 = cycle after the acceptance edge) of the first
  // response pulse and of the mem_enable strobe (0 = never strobes)
  typedef struct {
    logic        rw;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          busy;
    logic        err;
    int          n;
    logic [31:0] d0;
    logic [31:0] step;
    int          rcyc;
    int          ecyc;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic rw, input logic [2:0] size, input logic [31:0] addr,
                              input logic [31:0] wdata, input int busy, input logic err,
                              input int n, input logic [31:0] d0, input logic [31:0] step,
                              input int rcyc, input int ecyc);
    vec_t v;
    v.rw = rw; v.size = size; v.addr = addr; v.wdata = wdata; v.busy = busy;
    v.err = err; v.n = n; v.d0 = d0; v.step = step; v.rcyc = rcyc; v.ecyc = ecyc;
    return v;
  endfunction

  task automatic run_vec(input int id, input vec_t v);
    int cyc, beat, n_en;
    bit done;
    @(negedge clk);
    chk($sformatf("v%0d_ready", id), 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_rw    = v.rw;
    req_size  = v.size;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    mem_busy  = (v.busy > 0);
    cyc = 0; beat = 0; n_en = 0; done = 1'b0;
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) req_valid = 1'b0;
      if (mem_enable) begin
        n_en++;
        chk($sformatf("v%0d_en_cyc", id), 32'(cyc), 32'(v.ecyc));
        chk($sformatf("v%0d_en_busy", id), 32'(mem_busy), 32'd0);
        chk($sformatf("v%0d_mem_addr", id), mem_addr, v.addr);
        chk($sformatf("v%0d_mem_size", id), 32'(mem_access_size), 32'(v.size));
        chk($sformatf("v%0d_mem_rw", id), 32'(mem_rw), 32'(v.rw));
        if (v.rw) chk($sformatf("v%0d_mem_din", id), mem_din, v.wdata);
      end
      if (resp_valid) begin
        if (beat == 0) chk($sformatf("v%0d_resp_cyc", id), 32'(cyc), 32'(v.rcyc));
        chk($sformatf("v%0d_b%0d_err", id, beat), 32'(resp_err), 32'(v.err));
        chk($sformatf("v%0d_b%0d_data", id, beat), resp_data, v.d0 + 32'(beat) * v.step);
        chk($sformatf("v%0d_b%0d_index", id, beat), 32'(resp_index), 32'(beat));
        chk($sformatf("v%0d_b%0d_last", id, beat), 32'(resp_last), 32'(beat == v.n - 1));
        beat++;
        if (resp_last) done = 1'b1;
      end
      if (cyc == v.busy) mem_busy = 1'b0;
    end
    mem_busy = 1'b0;
    chk($sformatf("v%0d_done", id), 32'(done), 32'd1);
    chk($sformatf("v%0d_beats", id), 32'(beat), 32'(v.n));
    chk($sformatf("v%0d_n_enable", id), 32'(n_en), 32'(v.ecyc != 0));
  endtask

  // ---------------- test sequence -------------------------------------------
  initial begin
    int  pulses;
    bit  found;
    rst = 1'b1; init_mem = 1'b1;
    req_valid = 1'b0; req_rw = 1'b0; req_size = '0; req_addr = '0; req_wdata = '0;
    mem_busy = 1'b0;

    //            rw    size   addr           wdata          busy err n   d0            step rcyc ecyc
    vt.push_back(mk(1'b0, 3'd2, 32'h8002_0020, 32'h0,         0, 1'b0, 8, 32'h0000_1000, 1, 3, 1));
    vt.push_back(mk(1'b1, 3'd4, 32'h8002_0003, 32'h0000_00A5, 0, 1'b0, 1, 32'h0,         0, 2, 1));
    vt.push_back(mk(1'b0, 3'd4, 32'h8002_0003, 32'h0,         0, 1'b0, 1, 32'h0000_00A5, 0, 3, 1));
    vt.push_back(mk(1'b0, 3'd0, 32'h8002_0002, 32'h0,         0, 1'b1, 1, 32'h0,         0, 1, 0));
    vt.push_back(mk(1'b1, 3'd1, 32'h8002_0000, 32'h1111_2222, 0, 1'b1, 1, 32'h0,         0, 1, 0));
    vt.push_back(mk(1'b0, 3'd0, 32'h8002_0400, 32'h0,         0, 1'b1, 1, 32'h0,         0, 1, 0));
    vt.push_back(mk(1'b0, 3'd0, 32'h8002_0010, 32'h0,         5, 1'b0, 1, 32'h0000_0FFC, 0, 8, 6));
    vt.push_back(mk(1'b0, 3'd5, 32'h8002_0020, 32'h0,         0, 1'b0, 1, 32'h0000_1000, 0, 3, 1));
    vt.push_back(mk(1'b0, 3'd5, 32'h8002_0021, 32'h0,         0, 1'b1, 1, 32'h0,         0, 1, 0));
    vt.push_back(mk(1'b0, 3'd3, 32'h8002_03C4, 32'h0,         0, 1'b1, 1, 32'h0,         0, 1, 0));
    vt.push_back(mk(1'b0, 3'd3, 32'h8002_03C0, 32'h0,         0, 1'b0, 16, 32'h0000_10E8, 1, 3, 1));
    vt.push_back(mk(1'b1, 3'd0, 32'h8002_03FC, 32'h1234_5678, 0, 1'b0, 1, 32'h0,         0, 2, 1));
    vt.push_back(mk(1'b0, 3'd4, 32'h8002_03FF, 32'h0,         0, 1'b0, 1, 32'h0000_0012, 0, 3, 1));
    vt.push_back(mk(1'b0, 3'd6, 32'h8002_0000, 32'h0,         0, 1'b1, 1, 32'h0,         0, 1, 0));
    vt.push_back(mk(1'b0, 3'd0, 32'h7FFF_FFFC, 32'h0,         0, 1'b1, 1, 32'h0,         0, 1, 0));
    vt.push_back(mk(1'b1, 3'd5, 32'h8002_0102, 32'hBEEF_1234, 0, 1'b0, 1, 32'h0,         0, 2, 1));
    vt.push_back(mk(1'b0, 3'd5, 32'h8002_0102, 32'h0,         0, 1'b0, 1, 32'h0000_1234, 0, 3, 1));
`ifdef MEM_MASTER_TIMEOUT_EN
    vt.push_back(mk(1'b0, 3'd0, 32'h8002_0010, 32'h0,        10, 1'b1, 1, 32'h0,         0, 5, 0));
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    init_mem = 1'b0;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_mem_enable", 32'(mem_enable), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < vt.size(); i++) run_vec(i, vt[i]);

    // reset during beat 3 of a 16-beat read at offset 0x40 (word 16)
    @(negedge clk);
    req_valid = 1'b1; req_rw = 1'b0; req_size = 3'd3; req_addr = 32'h8002_0040;
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge clk);
      if (c == 0) req_valid = 1'b0;
      if (resp_valid && resp_index == 4'd3) found = 1'b1;
    end
    chk("mid_found_beat3", 32'(found), 32'd1);
    chk("mid_beat3_data", resp_data, 32'h0000_100B);
    rst = 1'b1;
    #1;
    chk("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("mid_rst_resp_index", 32'(resp_index), 32'd0);
    chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
    chk("mid_rst_mem_addr", mem_addr, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (resp_valid) pulses++;
    end
    chk("mid_rst_no_resp", 32'(pulses), 32'd0);
    run_vec(100, vt[0]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
